// File: rtl/burst_ctrl_pkg.sv
// Shared types and constants for the burst command front end.
// Width/stride values track bt_top::ADDR_WIDTH/DATA_WIDTH/ADDR_MAX and addr_mod::STRIDE downstream.
package burst_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH        = 8;
    localparam int unsigned DATA_WIDTH        = 16;
    localparam int unsigned ADDR_MAX          = (1 << ADDR_WIDTH) - 1;
    localparam int unsigned STRIDE            = 1;
    localparam int unsigned DEFAULT_LEN_WIDTH = 5;

    typedef logic [ADDR_WIDTH-1:0]        addr_t;
    typedef logic [DATA_WIDTH-1:0]        data_t;
    typedef logic [DEFAULT_LEN_WIDTH-1:0] len_t;

    typedef logic [2:0] state_t;
    localparam state_t StIdle   = 3'd0;
    localparam state_t StWr     = 3'd1;
    localparam state_t StRd     = 3'd2;
    localparam state_t StWdone  = 3'd3;
    localparam state_t StRdrain = 3'd4;

    // Last beat address without wrap, for the out-of-range check.
    function automatic logic [31:0] burst_end(input addr_t addr, input logic [31:0] len);
        return 32'(addr) + len * STRIDE;
    endfunction

endpackage

// File: rtl/burst_rd_tracker.sv
// Shift pipe of {valid, last} that times read responses to the SRAM read latency.
module burst_rd_tracker #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic issue,
    input  logic issue_last,
    output logic resp_valid,
    output logic resp_last,
    output logic empty
);

    localparam int unsigned Depth = RD_LAT + 1;

    logic [Depth-1:0] vld_q;
    logic [Depth-1:0] lst_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q <= Depth'({vld_q, issue});
            lst_q <= Depth'({lst_q, issue & issue_last});
        end
    end

    assign resp_valid = vld_q[Depth-1];
    assign resp_last  = lst_q[Depth-1];
    assign empty      = ~|vld_q;

endmodule

// File: rtl/burst_req_ctrl.sv
// Burst command front end for burst_transaction_top: expands one command into per-beat accesses.
// Optional BURST_BOUND_CHK_EN rejects commands whose last beat would pass ADDR_MAX.
module burst_req_ctrl
    import burst_ctrl_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = DEFAULT_LEN_WIDTH,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rresp_valid,
    output logic [DATA_WIDTH-1:0] rresp_data,
    output logic                  rresp_last,
    output logic                  cmd_err,
    output logic                  burst_en,
    output logic [ADDR_WIDTH-1:0] addr_top,
    output logic                  wren,
    output logic                  rden,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    state_t               state_q, state_d;
    addr_t                cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                 cmd_ready_q;
    logic                 cmd_err_q;
    logic                 wren_q;
    logic                 rden_q;
    data_t                wr_data_q;

    logic cmd_hs;
    logic wr_beat;
    logic rd_beat;
    logic last_beat;
    logic bound_err;
    logic trk_valid;
    logic trk_last;
    logic trk_empty;

    assign cmd_hs    = cmd_valid && cmd_ready;
    assign wr_beat   = (state_q == StWr) && wdata_valid;
    assign rd_beat   = (state_q == StRd);
    assign last_beat = (beat_cnt_q == len_q);

`ifdef BURST_BOUND_CHK_EN
    assign bound_err = burst_end(cmd_addr, 32'(cmd_len)) > 32'(ADDR_MAX);
`else
    assign bound_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            StIdle: begin
                if (cmd_hs && !bound_err) begin
                    cur_addr_d = cmd_addr;
                    len_d      = cmd_len;
                    beat_cnt_d = '0;
                    state_d    = cmd_write ? StWr : StRd;
                end
            end
            StWr: begin
                if (wr_beat) begin
                    cur_addr_d = cur_addr_q + addr_t'(STRIDE);
                    beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                    if (last_beat) begin
                        state_d = StWdone;
                    end
                end
            end
            StRd: begin
                cur_addr_d = cur_addr_q + addr_t'(STRIDE);
                beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                if (last_beat) begin
                    state_d = StRdrain;
                end
            end
            StWdone: state_d = StIdle;
            StRdrain: begin
                if (trk_empty) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // wren/rden/wr_data lag addr_top by one cycle to meet the downstream address register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            cmd_ready_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            wren_q      <= 1'b0;
            rden_q      <= 1'b0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            cmd_ready_q <= (state_d == StIdle);
            cmd_err_q   <= cmd_hs && bound_err;
            wren_q      <= wr_beat;
            rden_q      <= rd_beat;
            wr_data_q   <= wr_beat ? wdata : '0;
        end
    end

    burst_rd_tracker #(
        .RD_LAT (RD_LAT)
    ) u_rd_tracker (
        .clk        (clk),
        .rstn       (rstn),
        .issue      (rd_beat),
        .issue_last (last_beat),
        .resp_valid (trk_valid),
        .resp_last  (trk_last),
        .empty      (trk_empty)
    );

    assign cmd_ready   = cmd_ready_q;
    assign cmd_err     = cmd_err_q;
    assign wdata_ready = (state_q == StWr);
    assign addr_top    = (state_q == StWr || state_q == StRd) ? cur_addr_q : '0;
    assign wren        = wren_q;
    assign rden        = rden_q;
    assign wr_data     = wr_data_q;
    assign burst_en    = 1'b0;
    assign rresp_valid = trk_valid;
    assign rresp_last  = trk_last;
    assign rresp_data  = trk_valid ? rd_data : '0;

endmodule

// File: tb/tb_burst_req_ctrl.sv
// Scoreboard bench for burst_req_ctrl with a behavioural downstream address register and SRAM.
module tb_burst_req_ctrl;
    import burst_ctrl_pkg::*;

    localparam int unsigned LW = 5;
    localparam int unsigned RL = 1;
`ifdef BURST_BOUND_CHK_EN
    localparam bit BoundChk = 1'b1;
`else
    localparam bit BoundChk = 1'b0;
`endif

    typedef struct packed { addr_t addr; data_t data; } wr_exp_t;
    typedef struct packed { data_t data; logic last; } rsp_exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic cmd_valid, cmd_ready, cmd_write;
    addr_t cmd_addr;
    logic [LW-1:0] cmd_len;
    logic wdata_valid, wdata_ready;
    data_t wdata;
    logic rresp_valid, rresp_last, cmd_err, burst_en, wren, rden;
    data_t rresp_data, wr_data, rd_data;
    addr_t addr_top;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_done_cyc = -1;
    int exp_err = 0;

    wr_exp_t  exp_wr[$];
    addr_t    exp_rd[$];
    rsp_exp_t exp_rsp[$];
    int       rden_cyc[$];
    data_t    wbuf[$];

    data_t ref_mem [ADDR_MAX+1] = '{default: '0};
    data_t mem [ADDR_MAX+1] = '{default: '0};
    data_t rd_pipe [RL];
    addr_t sram_addr;

    wr_exp_t  we;
    rsp_exp_t re;
    int       rc;

    always #5 clk = ~clk;

    burst_req_ctrl #(
        .LEN_WIDTH (LW),
        .RD_LAT    (RL)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rresp_valid (rresp_valid),
        .rresp_data  (rresp_data),
        .rresp_last  (rresp_last),
        .cmd_err     (cmd_err),
        .burst_en    (burst_en),
        .addr_top    (addr_top),
        .wren        (wren),
        .rden        (rden),
        .wr_data     (wr_data),
        .rd_data     (rd_data)
    );

    // Downstream: registered address in pass-through mode, SRAM with RL read latency.
    always @(posedge clk) begin
        sram_addr <= addr_top;
        if (wren) mem[sram_addr] <= wr_data;
        rd_pipe[0] <= rden ? mem[sram_addr] : '0;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign rd_data = rd_pipe[RL-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic int outstanding();
        return exp_wr.size() + exp_rd.size() + exp_rsp.size() + rden_cyc.size();
    endfunction

    // Monitor: pops expectations whenever the DUT presents a beat.
    always @(negedge clk) begin
        if (rstn) begin
            check("wren_rden_excl", 32'(wren & rden), 0);
            check("burst_en_low", 32'(burst_en), 0);
            if (wren) begin
                check("wren_expected", 32'(exp_wr.size() != 0), 1);
                if (exp_wr.size() != 0) begin
                    we = exp_wr.pop_front();
                    check("wr_addr", 32'(sram_addr), 32'(we.addr));
                    check("wr_data", 32'(wr_data), 32'(we.data));
                end
                last_done_cyc = cyc;
            end
            if (rden) begin
                check("rden_expected", 32'(exp_rd.size() != 0), 1);
                if (exp_rd.size() != 0) check("rd_addr", 32'(sram_addr), 32'(exp_rd.pop_front()));
                rden_cyc.push_back(cyc);
            end
            if (rresp_valid) begin
                check("rresp_expected", 32'(exp_rsp.size() != 0 && rden_cyc.size() != 0), 1);
                if (exp_rsp.size() != 0 && rden_cyc.size() != 0) begin
                    re = exp_rsp.pop_front();
                    rc = rden_cyc.pop_front();
                    check("rresp_data", 32'(rresp_data), 32'(re.data));
                    check("rresp_last", 32'(rresp_last), 32'(re.last));
                    check("rresp_latency", 32'(cyc - rc), RL);
                end
                last_done_cyc = cyc;
            end
            if (cmd_err) begin
                check("cmd_err_expected", 32'(exp_err > 0), 1);
                if (exp_err > 0) exp_err--;
            end
            if (cmd_valid && cmd_ready) begin
                check("accept_after_retire", 32'(outstanding() == 0 && cyc > last_done_cyc), 1);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 32'({cmd_ready, wdata_ready, rresp_valid, rresp_last,
                                    cmd_err, burst_en, wren, rden}), 0);
        check({tag, "_addr_top"}, 32'(addr_top), 0);
        check({tag, "_data"}, 32'({rresp_data, wr_data}), 0);
    endtask

    task automatic stream_wdata(input int gap_after, input int gap_len, input int gap_pct);
        int i = 0;
        int n = 0;
        int hold = 0;
        while (i < wbuf.size() && n < 2000) begin
            @(posedge clk); #1;
            if (hold > 0) begin
                wdata_valid = 1'b0;
                hold--;
            end else begin
                wdata_valid = ($urandom_range(0, 99) >= gap_pct);
            end
            wdata = wbuf[i];
            @(negedge clk);
            n++;
            if (wdata_valid && wdata_ready) begin
                i++;
                if (i == gap_after) hold = gap_len;
            end
        end
        @(posedge clk); #1;
        wdata_valid = 1'b0;
        if (i < wbuf.size()) check("wdata_timeout", i, wbuf.size());
    endtask

    // Issue one command and push the expected beats it implies.
    task automatic send_cmd(input logic wr, input int unsigned addr, input int unsigned len,
                            input bit rnd, input int unsigned base, input int gap_after,
                            input int gap_len, input int gap_pct);
        int n = 0;
        int unsigned fin;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr_t'(addr);
        cmd_len   = LW'(len);
        @(negedge clk);
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_timeout", 32'(cmd_ready), 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        fin = addr + len * STRIDE;
        if (BoundChk && fin > ADDR_MAX) begin
            exp_err++;
            return;
        end
        wbuf.delete();
        for (int i = 0; i <= int'(len); i++) begin
            addr_t a;
            data_t d;
            a = addr_t'(addr + i * STRIDE);
            if (wr) begin
                d = rnd ? data_t'($urandom) : data_t'(base + i);
                wbuf.push_back(d);
                ref_mem[a] = d;
                exp_wr.push_back('{addr: a, data: d});
            end else begin
                exp_rd.push_back(a);
                exp_rsp.push_back('{data: ref_mem[a], last: (i == int'(len))});
            end
        end
        if (wr) stream_wdata(gap_after, gap_len, gap_pct);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_len     = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rstn = 1'b1;

        // Write A0..A3 at 4, read back, gapped write, single-beat read.
        send_cmd(1'b1, 4, 3, 1'b0, 'hA0, -1, 0, 0);
        send_cmd(1'b0, 4, 3, 1'b0, 0, -1, 0, 0);
        send_cmd(1'b1, 4, 3, 1'b0, 'hB0, 1, 2, 0);
        send_cmd(1'b0, 4, 3, 1'b0, 0, -1, 0, 0);
        send_cmd(1'b1, 9, 0, 1'b0, 'hC9, -1, 0, 0);
        send_cmd(1'b0, 9, 0, 1'b0, 0, -1, 0, 0);

        // Reset in the middle of an 8-beat read; the remainder is abandoned.
        send_cmd(1'b0, 16, 7, 1'b0, 0, -1, 0, 0);
        repeat (4) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_wr.delete();
        exp_rd.delete();
        exp_rsp.delete();
        rden_cyc.delete();
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        send_cmd(1'b0, 9, 0, 1'b0, 0, -1, 0, 0);

        // Burst crossing the top of the address space.
        send_cmd(1'b1, ADDR_MAX - 1, 3, 1'b0, 'hD0, -1, 0, 0);
        send_cmd(1'b0, ADDR_MAX - 1, 3, 1'b0, 0, -1, 0, 0);
        send_cmd(1'b0, 0, 1, 1'b0, 0, -1, 0, 0);

        for (int k = 0; k < 40; k++) begin
            send_cmd(1'($urandom_range(0, 1)), $urandom_range(0, ADDR_MAX),
                     $urandom_range(0, 31), 1'b1, 0, -1, 0, $urandom_range(0, 40));
        end

        n = 0;
        while ((outstanding() != 0 || exp_err != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("drain_wr", exp_wr.size(), 0);
        check("drain_rd", exp_rd.size(), 0);
        check("drain_rsp", exp_rsp.size(), 0);
        check("drain_err", exp_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/burst_req_ctrl.md
Name: burst_req_ctrl

Overview:
- Command-level front end directly upstream of burst_transaction_top.
- Accepts one burst command at a time: start address, beat count, read/write.
- Streams per-beat wren/rden/addr_top/wr_data into burst_transaction_top and returns read beats as a response stream with a last flag.
- Computes every beat address internally using stride addr_mod::STRIDE. Drives burst_en low at all times, so the downstream address stage runs in pass-through mode with its one-cycle register.

Parameters:
- LEN_WIDTH, 5, width of cmd_len. Maximum burst is 2**LEN_WIDTH beats; cmd_len encodes beats-1.
- RD_LAT, 1, cycles from rden/addr presented at the SRAM to valid rd_data.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
- cmd_write  input  1  1 = write burst, 0 = read burst
- cmd_addr  input  bt_top::ADDR_WIDTH  start address
- cmd_len  input  LEN_WIDTH  beats-1
- wdata_valid  input  1  write beat offered
- wdata_ready  output  1  write beat consumed when wdata_valid && wdata_ready
- wdata  input  bt_top::DATA_WIDTH  write beat data
- rresp_valid  output  1  read beat valid; no backpressure
- rresp_data  output  bt_top::DATA_WIDTH  read beat data
- rresp_last  output  1  final beat of the read burst
- cmd_err  output  1  one-cycle pulse, command rejected (feature only; tied 0 otherwise)
- burst_en  output  1  to burst_transaction_top; constant 0
- addr_top  output  bt_top::ADDR_WIDTH  beat address to burst_transaction_top
- wren  output  1  to burst_transaction_top
- rden  output  1  to burst_transaction_top
- wr_data  output  bt_top::DATA_WIDTH  to burst_transaction_top
- rd_data  input  bt_top::DATA_WIDTH  from burst_transaction_top

Behaviour:
- Reset (rstn low, async): state IDLE. All outputs 0, including cmd_ready, wdata_ready, rresp_*, wren, rden, addr_top, wr_data. Counters and the read tracker are cleared. A burst in flight is abandoned and no response is issued for it.
- FSM states:
  - IDLE:
    - cmd_ready=1.
    - On handshake, latch addr/len/write.
    - Go to WR (write) or RD (read).
  - WR:
    - wdata_ready=1.
    - On each wdata handshake, present addr_top = cur_addr for one cycle, then cur_addr += STRIDE and beat_cnt += 1.
    - If wdata_valid is 0, no beat issues; the address holds.
    - On the last beat (beat_cnt==len), go to WDONE.
  - RD:
    - Issue one beat per cycle, with no stall, same address progression.
    - On the last beat, go to RDRAIN.
  - WDONE: one cycle, lets the final wren retire; then IDLE.
  - RDRAIN: wait until the read tracker is empty, then IDLE.
- Alignment: the downstream address register adds one cycle. wren/rden/wr_data are therefore registered one cycle after addr_top, so they coincide with the registered SRAM address.
- Read return:
  - rresp_valid asserts exactly 1+RD_LAT cycles after the beat's addr_top cycle.
  - rresp_data = rd_data in that cycle.
  - rresp_last is set on the beat with beat_cnt==len.
- Arithmetic: cur_addr is ADDR_WIDTH bits and wraps modulo 2**ADDR_WIDTH. Without the feature, a burst crossing the top wraps to 0.
- Boundaries:
  - cmd_len=0 is a single beat: rresp_valid and rresp_last in the same cycle.
  - No new command is accepted until the previous burst fully retires, including read drain.
  - A command arriving in the same cycle the FSM returns to IDLE is accepted that cycle (cmd_ready is a function of state only).
  - wren and rden are never both 1.

Optional Feature:
- Macro: BURST_BOUND_CHK_EN.
- Defined:
  - In IDLE, compute end = cmd_addr + cmd_len*STRIDE at full precision.
  - If end > bt_top::ADDR_MAX, the handshake still completes, cmd_err pulses for 1 cycle, no beats issue, and the FSM stays in IDLE.
- Undefined: no check, cmd_err tied 0, addresses wrap.

Decomposition:
- Package burst_ctrl_pkg:
  - state enum {IDLE, WR, RD, WDONE, RDRAIN}
  - LEN_WIDTH default
  - typedefs for address, data and len
  - the package reuses bt_top widths and addr_mod::STRIDE.
- Sub-module burst_rd_tracker: a RD_LAT+1-deep shift pipe of {valid, last}. Its inputs are the read-beat issue flag and the last flag; its outputs are rresp_valid, rresp_last and an empty flag.

Test Plan:
1. Write cmd_addr=4, cmd_len=3, STRIDE=1, wdata 0xA0..0xA3 back-to-back → wren on SRAM addrs 4,5,6,7 on consecutive cycles, cmd_ready low until WDONE exits.
2. Read the same burst → four rresp_valid at 1+RD_LAT cycles per beat, data 0xA0..0xA3, rresp_last only on 0xA3.
3. Write cmd_len=3 with wdata_valid low for 2 cycles after beat 1 → no wren during the gap, addresses still 4,5,6,7 in order.
4. Read cmd_len=0 at addr 9 → single rresp with rresp_last=1, then IDLE.
5. rstn pulled low mid-read after 2 beats → all outputs 0 immediately, no further rresp, a new command is accepted after release.
6. With BURST_BOUND_CHK_EN, cmd_addr=ADDR_MAX-1, cmd_len=3 → cmd_err pulse, no wren/rden. Without the macro → addresses wrap to 0.
